reg_file_2r1w: RTL

- Parametrised register file with one write port and two read ports; replaces the fixed 8-entry, 13-bit combinational read selector in the RegisterFile block.
- Each read port selects any entry by binary address; read data is registered (1-cycle latency) and qualified by a valid strobe.
- Stores game state words (timer snapshots, best times, scores) and feeds the display and compare logic.

---
 rtl/reg_file_2r1w_if.sv | 27 ++
 rtl/reg_file_2r1w.sv | 104 ++++++++++
 2 files changed

// File: rtl/reg_file_2r1w_if.sv
// reg_file_2r1w_if: write/read request and read response bundle for reg_file_2r1w.
interface reg_file_2r1w_if #(
    parameter int WIDTH = 13,
    parameter int DEPTH = 8
);
    localparam int ADDR_W = $clog2(DEPTH);

    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [WIDTH-1:0]  wr_data;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr_a;
    logic [ADDR_W-1:0] rd_addr_b;
    logic [WIDTH-1:0]  rd_data_a;
    logic [WIDTH-1:0]  rd_data_b;
    logic              rd_valid;

    modport master (
        output wr_en, wr_addr, wr_data, rd_en, rd_addr_a, rd_addr_b,
        input  rd_data_a, rd_data_b, rd_valid
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, rd_en, rd_addr_a, rd_addr_b,
        output rd_data_a, rd_data_b, rd_valid
    );
endinterface

// File: rtl/reg_file_2r1w.sv
// reg_file_2r1w: flop-based register file, one write port, two registered read ports.
// Define REG_FILE_2R1W_BYPASS_EN for write-first collisions; default build is read-first.
module reg_file_2r1w_rd #(
    parameter int WIDTH  = 13,
    parameter int DEPTH  = 8,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        rd_en,
    input  logic [ADDR_W-1:0]           rd_addr,
    input  logic [DEPTH-1:0][WIDTH-1:0] mem,
    input  logic                        wr_ok,
    input  logic [ADDR_W-1:0]           wr_addr,
    input  logic [WIDTH-1:0]            wr_data,
    output logic [WIDTH-1:0]            rd_data
);
    logic             rd_ok;
    logic [WIDTH-1:0] sel;

    if (DEPTH == (1 << ADDR_W)) begin : g_full
        assign rd_ok = 1'b1;
    end else begin : g_part
        assign rd_ok = rd_addr < ADDR_W'(DEPTH);
    end

`ifdef REG_FILE_2R1W_BYPASS_EN
    // Write-first: a same-cycle write to this port's address wins over the stored word.
    always_comb begin
        sel = rd_ok ? mem[rd_addr] : '0;
        if (wr_ok && wr_addr == rd_addr) sel = wr_data;
    end
`else
    logic unused_wr;
    assign unused_wr = ^{wr_ok, wr_addr, wr_data};
    assign sel = rd_ok ? mem[rd_addr] : '0;
`endif

    always_ff @(posedge clk) begin
        if (rst)        rd_data <= '0;
        else if (rd_en) rd_data <= sel;
    end
endmodule

module reg_file_2r1w #(
    parameter int WIDTH = 13,
    parameter int DEPTH = 8
) (
    input logic           clk,
    input logic           rst,
    reg_file_2r1w_if.slave bus
);
    localparam int ADDR_W = $clog2(DEPTH);
    localparam int NUM_RD = 2;
    localparam int STAGES = 1;

    logic [DEPTH-1:0][WIDTH-1:0]    mem;
    logic                           wr_ok;
    logic [NUM_RD-1:0][ADDR_W-1:0]  rd_addr;
    logic [NUM_RD-1:0][WIDTH-1:0]   rd_data;
    logic [STAGES:0]                vld_pipe;

    // Out-of-range addresses only exist when DEPTH is not a power of two.
    if (DEPTH == (1 << ADDR_W)) begin : g_wr_full
        assign wr_ok = bus.wr_en;
    end else begin : g_wr_part
        assign wr_ok = bus.wr_en && (bus.wr_addr < ADDR_W'(DEPTH));
    end

    always_ff @(posedge clk) begin
        if (rst)        mem <= '0;
        else if (wr_ok) mem[bus.wr_addr] <= bus.wr_data;
    end

    assign vld_pipe[0] = bus.rd_en;
    always_ff @(posedge clk) begin
        if (rst) vld_pipe[STAGES:1] <= '0;
        else     vld_pipe[STAGES:1] <= vld_pipe[STAGES-1:0];
    end

    assign rd_addr = {bus.rd_addr_b, bus.rd_addr_a};

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        reg_file_2r1w_rd #(
            .WIDTH  (WIDTH),
            .DEPTH  (DEPTH),
            .ADDR_W (ADDR_W)
        ) u_rd (
            .clk     (clk),
            .rst     (rst),
            .rd_en   (bus.rd_en),
            .rd_addr (rd_addr[i]),
            .mem     (mem),
            .wr_ok   (wr_ok),
            .wr_addr (bus.wr_addr),
            .wr_data (bus.wr_data),
            .rd_data (rd_data[i])
        );
    end

    assign bus.rd_data_a = rd_data[0];
    assign bus.rd_data_b = rd_data[1];
    assign bus.rd_valid  = vld_pipe[STAGES];
endmodule
